// File: rtl/jtframe_lfbuf_sdram.sv
// ----------------------------------------------------------------------------
// jtframe_lfbuf_sdram
//
// Moves whole video lines between a local line buffer and a frame-sized SDRAM
// region. A finished line (ln_done) is copied from the line buffer into
// SDRAM. At the start of each horizontal blank (lhbl falling) the next line
// to be displayed is read back from the other frame half and written into
// the scan buffer one word at a time.
//
// Ports
//   clk, rst            system clock, asynchronous active-high reset
//   lhbl, vrender       horizontal blank (active low), next rendered line
//   frame               frame half used for writes; reads use ~frame
//   ln_v, ln_done       line just drawn, one-cycle "line finished" pulse
//   line                toggles on every accepted ln_done
//   fb_addr, fb_din     line-buffer read port (synchronous, one-cycle latency)
//   fb_clr, fb_done     clear strobe for fb_addr, end-of-line-copy pulse
//   rd_addr, fb_dout,   scan-buffer write port for words read from SDRAM
//   scr_we
//   mem_*               SDRAM request port, mem_ok pulses once per word
//   ovr_cnt             read-overrun count
//
// Configuration
//   JTFRAME_LFBUF_OVR_EN  when defined ovr_cnt counts read restarts and
//                         saturates at 255; otherwise it is tied to zero.
// ----------------------------------------------------------------------------
module jtframe_lfbuf_sdram #(
  parameter int VW   = 8,
  parameter int HW   = 9,
  parameter int HLEN = 256
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            lhbl,
  input  logic [VW-1:0]   vrender,
  input  logic            frame,
  input  logic [VW-1:0]   ln_v,
  input  logic            ln_done,
  output logic            line,
  output logic [HW-1:0]   fb_addr,
  input  logic [15:0]     fb_din,
  output logic            fb_clr,
  output logic            fb_done,
  output logic [HW-1:0]   rd_addr,
  output logic [15:0]     fb_dout,
  output logic            scr_we,
  output logic            mem_cs,
  output logic            mem_we,
  output logic [VW+HW:0]  mem_addr,
  output logic [15:0]     mem_din,
  input  logic [15:0]     mem_dout,
  input  logic            mem_ok,
  output logic [7:0]      ovr_cnt
);

  typedef enum logic [1:0] {IDLE, WR_ADDR, WR_REQ, RD_REQ} state_t;

  localparam logic [HW-1:0] LAST = HW'(HLEN - 1);

  state_t          state, next_state;
  logic [VW-1:0]   wr_v, rd_v;
  logic [HW-1:0]   wr_h, rd_h;
  logic            wr_pend, rd_pend;
  logic            wr_ph;      // first WR_REQ cycle: line buffer still fetching
  logic            wr_rdy;     // mem_din holds the current word
  logic            lhbl_l;

  logic lhbl_fall, rd_go, wr_ack, rd_ack, wr_last, rd_last;

  assign lhbl_fall = lhbl_l & ~lhbl;
  assign rd_go     = rd_pend | lhbl_fall;
  assign wr_last   = (wr_h == LAST);
  assign rd_last   = (rd_h == LAST);
  assign wr_ack    = (state == WR_REQ) && wr_rdy && mem_ok;
  assign rd_ack    = (state == RD_REQ) && mem_ok;

  // The write request is raised only once mem_din is valid, so a controller
  // may sample the data on any cycle of the request.
  assign mem_cs   = (state == RD_REQ) || ((state == WR_REQ) && wr_rdy);
  assign mem_we   = (state == WR_REQ) && wr_rdy;
  assign mem_addr = (state == RD_REQ) ? {~frame, rd_v, rd_h} : {frame, wr_v, wr_h};

  // NOTE: every output of a combinational block gets a default first; a path
  // that leaves it unassigned would otherwise infer a latch.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (rd_pend) next_state = RD_REQ;
               else if (wr_pend) next_state = WR_ADDR;
      WR_ADDR: next_state = rd_go ? RD_REQ : WR_REQ;
      WR_REQ:  if (wr_ack) begin
                 if (rd_go)        next_state = RD_REQ;
                 else if (wr_last) next_state = IDLE;
                 else              next_state = WR_ADDR;
               end
      RD_REQ:  if (rd_ack && rd_last && !lhbl_fall)
                 next_state = wr_pend ? WR_ADDR : IDLE;
      default: next_state = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // sees the values from before the edge, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      line    <= 1'b0;
      wr_v    <= '0;
      wr_h    <= '0;
      wr_pend <= 1'b0;
      rd_v    <= '0;
      rd_h    <= '0;
      rd_pend <= 1'b0;
      wr_ph   <= 1'b0;
      wr_rdy  <= 1'b0;
      lhbl_l  <= 1'b0;
      fb_addr <= '0;
      fb_clr  <= 1'b0;
      fb_done <= 1'b0;
      rd_addr <= '0;
      fb_dout <= '0;
      scr_we  <= 1'b0;
      mem_din <= '0;
    end else begin
      state   <= next_state;
      lhbl_l  <= lhbl;
      fb_clr  <= 1'b0;
      fb_done <= 1'b0;
      scr_we  <= 1'b0;

      // A new line is accepted only once the previous copy has finished.
      if (ln_done && !wr_pend) begin
        line    <= ~line;
        wr_v    <= ln_v;
        wr_h    <= '0;
        wr_pend <= 1'b1;
      end

      // Address goes out here; the buffer answers one cycle later, so the
      // data is captured on the second WR_REQ cycle.
      if (state == WR_ADDR) begin
        fb_addr <= wr_h;
        wr_ph   <= 1'b0;
        wr_rdy  <= 1'b0;
      end

      if (state == WR_REQ && !wr_rdy) begin
        wr_ph <= 1'b1;
        if (wr_ph) begin
          mem_din <= fb_din;
          wr_rdy  <= 1'b1;
        end
      end

      // fb_addr still points at the word just stored, so fb_clr hits it.
      if (wr_ack) begin
        fb_clr <= 1'b1;
        wr_rdy <= 1'b0;
        if (wr_last) begin
          fb_done <= 1'b1;
          wr_pend <= 1'b0;
          wr_h    <= '0;
        end else begin
          wr_h <= wr_h + 1'b1;
        end
      end

      if (rd_ack) begin
        fb_dout <= mem_dout;
        scr_we  <= 1'b1;
        rd_addr <= rd_h;
        if (rd_last) begin
          rd_pend <= 1'b0;
          rd_h    <= '0;
        end else begin
          rd_h <= rd_h + 1'b1;
        end
      end

      // Placed last: a new blank restarts the read even if a word was just
      // acknowledged in the same cycle.
      if (lhbl_fall) begin
        rd_pend <= 1'b1;
        rd_v    <= vrender + 1'b1;
        rd_h    <= '0;
      end
    end
  end

`ifdef JTFRAME_LFBUF_OVR_EN
  logic [7:0] ovr_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      ovr_q <= 8'd0;
    else if (lhbl_fall && rd_pend && ovr_q != 8'hff)
      ovr_q <= ovr_q + 8'd1;
  end

  assign ovr_cnt = ovr_q;
`else
  assign ovr_cnt = 8'd0;
`endif

endmodule

// File: tb/tb_jtframe_lfbuf_sdram.sv
module tb_jtframe_lfbuf_sdram;
  localparam int VW = 8, HW = 9, HLEN = 4, AW = VW + HW + 1;

`ifdef JTFRAME_LFBUF_OVR_EN
  localparam logic [7:0] EXP_OVR = 8'd1;
`else
  localparam logic [7:0] EXP_OVR = 8'd0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1, lhbl = 1'b1, frame = 1'b0, ln_done = 1'b0;
  logic [VW-1:0] vrender = '0, ln_v = '0;
  logic line, fb_clr, fb_done, scr_we, mem_cs, mem_we, mem_ok;
  logic [HW-1:0] fb_addr, rd_addr;
  logic [15:0] fb_din = '0, fb_dout, mem_din, mem_dout = '0;
  logic [AW-1:0] mem_addr;
  logic [7:0] ovr_cnt;
  logic mdl_ok = 1'b0, stray_ok = 1'b0, mem_en = 1'b1;
  int lat = 0;

  assign mem_ok = mdl_ok | stray_ok;

  always #5 clk = ~clk;

  jtframe_lfbuf_sdram #(.VW(VW), .HW(HW), .HLEN(HLEN)) dut (
    .clk(clk), .rst(rst), .lhbl(lhbl), .vrender(vrender), .frame(frame),
    .ln_v(ln_v), .ln_done(ln_done), .line(line), .fb_addr(fb_addr),
    .fb_din(fb_din), .fb_clr(fb_clr), .fb_done(fb_done), .rd_addr(rd_addr),
    .fb_dout(fb_dout), .scr_we(scr_we), .mem_cs(mem_cs), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_din(mem_din), .mem_dout(mem_dout),
    .mem_ok(mem_ok), .ovr_cnt(ovr_cnt)
  );

  // Line buffer: synchronous read, contents 1100+address.
  always @(posedge clk) fb_din <= 16'h1100 + 16'(fb_addr);

  // SDRAM: acknowledges two cycles after a request appears, read data A000+h.
  always @(posedge clk) begin
    mdl_ok <= 1'b0;
    if (rst || !mem_en || !mem_cs || mdl_ok) lat <= 0;
    else if (lat == 1) begin
      mdl_ok   <= 1'b1;
      lat      <= 0;
      mem_dout <= 16'hA000 + 16'(mem_addr[HW-1:0]);
    end else lat <= lat + 1;
  end

  typedef logic [AW+16:0] tx_t;  // {we, addr, data}
  tx_t obs_tx[$], exp_tx[$];
  logic [HW-1:0] obs_clr[$], exp_clr[$];
  logic [HW+15:0] obs_scr[$], exp_scr[$];
  int done_cnt = 0, clr_total = 0, done_at_clr = 0;
  int compared = 0, mismatched = 0;

  always @(negedge clk) if (!rst) begin
    if (mem_ok && mem_cs) obs_tx.push_back({mem_we, mem_addr, mem_we ? mem_din : mem_dout});
    if (fb_clr) begin obs_clr.push_back(fb_addr); clr_total++; end
    if (scr_we) obs_scr.push_back({rd_addr, fb_dout});
    if (fb_done) begin done_cnt++; done_at_clr = clr_total; end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push_wr(input logic half, input logic [VW-1:0] v, input logic [HW-1:0] h);
    exp_tx.push_back({1'b1, half, v, h, 16'h1100 + 16'(h)});
    exp_clr.push_back(h);
  endtask

  task automatic push_rd(input logic half, input logic [VW-1:0] v, input logic [HW-1:0] h);
    exp_tx.push_back({1'b0, half, v, h, 16'hA000 + 16'(h)});
    exp_scr.push_back({h, 16'hA000 + 16'(h)});
  endtask

  task automatic drain(input string tag);
    tx_t et, ot;
    logic [HW-1:0] ec, oc;
    logic [HW+15:0] es, os;
    check({tag, " tx count"}, 64'(obs_tx.size()), 64'(exp_tx.size()));
    check({tag, " clr count"}, 64'(obs_clr.size()), 64'(exp_clr.size()));
    check({tag, " scr count"}, 64'(obs_scr.size()), 64'(exp_scr.size()));
    while (exp_tx.size() > 0) begin
      et = exp_tx.pop_front();
      ot = (obs_tx.size() > 0) ? obs_tx.pop_front() : 'x;
      check({tag, " tx"}, 64'(ot), 64'(et));
    end
    while (exp_clr.size() > 0) begin
      ec = exp_clr.pop_front();
      oc = (obs_clr.size() > 0) ? obs_clr.pop_front() : 'x;
      check({tag, " clr addr"}, 64'(oc), 64'(ec));
    end
    while (exp_scr.size() > 0) begin
      es = exp_scr.pop_front();
      os = (obs_scr.size() > 0) ? obs_scr.pop_front() : 'x;
      check({tag, " scr"}, 64'(os), 64'(es));
    end
    obs_tx.delete(); obs_clr.delete(); obs_scr.delete();
  endtask

  task automatic pulse_ln(input logic [VW-1:0] v);
    ln_v = v; ln_done = 1'b1;
    @(negedge clk);
    ln_done = 1'b0;
  endtask

  task automatic fall_lhbl(input logic [VW-1:0] v);
    vrender = v; lhbl = 1'b0;
    repeat (3) @(negedge clk);
    lhbl = 1'b1;
  endtask

  task automatic wait_done(input int target, input string tag);
    for (int i = 0; i < 500 && done_cnt < target; i++) @(negedge clk);
    check({tag, " fb_done seen"}, 64'(done_cnt >= target), 64'd1);
  endtask

  task automatic wait_scr(input int n, input string tag);
    for (int i = 0; i < 500 && obs_scr.size() < n; i++) @(negedge clk);
    check({tag, " reads seen"}, 64'(obs_scr.size() >= n), 64'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic exp_line;
    int d0, c0;
    bit found;
    exp_line = 1'b0;

    // Reset values
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst mem_cs", 64'(mem_cs), 64'd0);
    check("rst mem_we", 64'(mem_we), 64'd0);
    check("rst line", 64'(line), 64'd0);
    check("rst fb_clr", 64'(fb_clr), 64'd0);
    check("rst fb_done", 64'(fb_done), 64'd0);
    check("rst scr_we", 64'(scr_we), 64'd0);
    check("rst fb_addr", 64'(fb_addr), 64'd0);
    check("rst rd_addr", 64'(rd_addr), 64'd0);
    check("rst mem_din", 64'(mem_din), 64'd0);
    check("rst fb_dout", 64'(fb_dout), 64'd0);
    check("rst ovr_cnt", 64'(ovr_cnt), 64'd0);

    // Stray mem_ok while idle is ignored
    stray_ok = 1'b1; @(negedge clk); stray_ok = 1'b0;
    repeat (5) @(negedge clk);
    check("stray mem_cs", 64'(mem_cs), 64'd0);
    check("stray scr_we count", 64'(obs_scr.size()), 64'd0);
    check("stray clr count", 64'(obs_clr.size()), 64'd0);
    check("stray done count", 64'(done_cnt), 64'd0);

    // Line write: frame 0, line 5
    exp_line = ~exp_line;
    for (int h = 0; h < HLEN; h++) push_wr(1'b0, 8'd5, HW'(h));
    d0 = done_cnt; c0 = clr_total;
    frame = 1'b0;
    pulse_ln(8'd5);
    wait_done(d0 + 1, "wr5");
    repeat (10) @(negedge clk);
    check("wr5 line", 64'(line), 64'(exp_line));
    check("wr5 done count", 64'(done_cnt), 64'(d0 + 1));
    check("wr5 done after last clr", 64'(done_at_clr), 64'(c0 + 4));
    drain("wr5");

    // Line read: vrender 9 -> line 10 from the other half
    for (int h = 0; h < HLEN; h++) push_rd(1'b1, 8'd10, HW'(h));
    fall_lhbl(8'd9);
    wait_scr(HLEN, "rd10");
    repeat (10) @(negedge clk);
    drain("rd10");

    // vrender wraps: 255 -> line 0
    for (int h = 0; h < HLEN; h++) push_rd(1'b1, 8'd0, HW'(h));
    fall_lhbl(8'd255);
    wait_scr(HLEN, "rd0");
    repeat (10) @(negedge clk);
    drain("rd0");

    // Read preempts a write between words; write resumes afterwards
    exp_line = ~exp_line;
    frame = 1'b1;
    for (int h = 0; h < 3; h++) push_wr(1'b1, 8'd7, HW'(h));
    for (int h = 0; h < HLEN; h++) push_rd(1'b0, 8'd21, HW'(h));
    push_wr(1'b1, 8'd7, HW'(3));
    d0 = done_cnt; c0 = clr_total;
    pulse_ln(8'd7);
    found = 1'b0;
    for (int i = 0; i < 300 && !found; i++) begin
      if (mem_cs && mem_we && mem_addr[HW-1:0] == HW'(2)) found = 1'b1;
      else @(negedge clk);
    end
    check("pre word2 in flight", 64'(found), 64'd1);
    fall_lhbl(8'd20);
    wait_done(d0 + 1, "pre");
    repeat (10) @(negedge clk);
    check("pre line", 64'(line), 64'(exp_line));
    check("pre done after last clr", 64'(done_at_clr), 64'(c0 + 4));
    check("pre fb_addr final", 64'(fb_addr), 64'd3);
    drain("pre");
    frame = 1'b0;

    // Reset in the middle of a write request
    mem_en = 1'b0;
    exp_line = ~exp_line;
    d0 = done_cnt;
    pulse_ln(8'd2);
    found = 1'b0;
    for (int i = 0; i < 100 && !found; i++) begin
      if (mem_cs && mem_we) found = 1'b1;
      else @(negedge clk);
    end
    check("rstmid write pending", 64'(found), 64'd1);
    check("rstmid line before", 64'(line), 64'(exp_line));
    rst = 1'b1;
    @(posedge clk); #1;
    check("rstmid mem_cs", 64'(mem_cs), 64'd0);
    check("rstmid line", 64'(line), 64'd0);
    exp_line = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    mem_en = 1'b1;
    repeat (30) @(negedge clk);
    check("rstmid no fb_done", 64'(done_cnt), 64'(d0));
    check("rstmid mem_cs idle", 64'(mem_cs), 64'd0);
    check("rstmid line after", 64'(line), 64'd0);
    drain("rstmid");

    // Second ln_done during a pending write is ignored
    exp_line = ~exp_line;
    for (int h = 0; h < HLEN; h++) push_wr(1'b0, 8'd3, HW'(h));
    d0 = done_cnt;
    pulse_ln(8'd3);
    @(negedge clk);
    pulse_ln(8'd9);
    wait_done(d0 + 1, "dup");
    repeat (20) @(negedge clk);
    check("dup line", 64'(line), 64'(exp_line));
    check("dup done count", 64'(done_cnt), 64'(d0 + 1));
    drain("dup");

    // Overrun: second blank while a read is stalled restarts it at h=0
    push_rd(1'b1, 8'd31, HW'(0));
    vrender = 8'd30; lhbl = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 100 && !found; i++) begin
      @(negedge clk);
      if (mdl_ok) begin found = 1'b1; mem_en = 1'b0; end
    end
    check("ovr first word", 64'(found), 64'd1);
    lhbl = 1'b1;
    repeat (6) @(negedge clk);
    check("ovr stalled cs", 64'(mem_cs), 64'd1);
    check("ovr stalled we", 64'(mem_we), 64'd0);
    fall_lhbl(8'd40);
    repeat (2) @(negedge clk);
    check("ovr count", 64'(ovr_cnt), 64'(EXP_OVR));
    check("ovr restart addr", 64'(mem_addr), 64'({1'b1, 8'd41, 9'd0}));
    for (int h = 0; h < HLEN; h++) push_rd(1'b1, 8'd41, HW'(h));
    mem_en = 1'b1;
    wait_scr(HLEN + 1, "ovr");
    repeat (10) @(negedge clk);
    drain("ovr");
    check("ovr count final", 64'(ovr_cnt), 64'(EXP_OVR));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
